// File: rtl/fir_stream_pkg.sv
// Shared widths, serializer state encoding and the per-lane round/saturate
// helper used by fir_result_serializer.
package fir_stream_pkg;

    localparam int LANES      = 5;
    localparam int IN_W       = 44;
    localparam int OUT_W      = 16;
    localparam int SHIFT      = 15;
    localparam int FIFO_DEPTH = 8;

    localparam int WORD_W  = LANES * OUT_W;
    localparam int ENTRY_W = WORD_W + 2;
    localparam int LANE_W  = $clog2(LANES);
    localparam int SATN_W  = $clog2(LANES + 1);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [0:0] {IDLE, EMIT} state_t;

    typedef struct packed {
        logic [OUT_W-1:0] q;
        logic             sat;
    } round_t;

    localparam logic signed [IN_W:0] RND_C   = (IN_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = -SAT_MAX - 1;

    // The sum is formed one bit wider than the lane so the rounding offset
    // can never wrap a large positive input into a negative one.
    function automatic round_t sat_round(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] r;
        logic signed [IN_W:0] q;
        round_t               res;
        r = $signed({x[IN_W-1], x}) + RND_C;
        q = r >>> SHIFT;
        if (q > SAT_MAX) begin
            res.q   = SAT_MAX[OUT_W-1:0];
            res.sat = 1'b1;
        end else if (q < SAT_MIN) begin
            res.q   = SAT_MIN[OUT_W-1:0];
            res.sat = 1'b1;
        end else begin
            res.q   = q[OUT_W-1:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_result_serializer_if.sv
// Word input from the FIR plus the per-lane output stream toward the DMA side.
interface fir_result_serializer_if;
    import fir_stream_pkg::*;

    logic [LANES*IN_W-1:0] in_data;
    logic                  in_valid;
    logic [1:0]            in_error;
    logic [OUT_W-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sop;
    logic                  out_eop;
    logic [1:0]            out_error;

    // in_valid qualifies one word per cycle and cannot be stalled. On the output,
    // a beat transfers on a rising clk with out_valid & out_ready; while out_valid
    // is high and not yet accepted, data/sop/eop/error hold and valid stays high.
    modport master (
        input  in_data, in_valid, in_error, out_ready,
        output out_data, out_valid, out_sop, out_eop, out_error
    );

    modport slave (
        output in_data, in_valid, in_error, out_ready,
        input  out_data, out_valid, out_sop, out_eop, out_error
    );

endinterface

// File: rtl/fir_result_serializer_fifo.sv
// Word FIFO between the rounding stage and the lane serializer; the caller
// only reads when non-empty and writes when not full or reading.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/fir_result_serializer.sv
// Rounds/saturates each FIR result lane, buffers whole words and emits them
// one lane per beat with sop/eop framing; keeps drop and saturation stats.
module fir_result_serializer
    import fir_stream_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    fir_result_serializer_if.master bus,
    input  logic                   clr_stats,
    output logic                   ovf_drop,
    output logic [15:0]            drop_count,
    output logic [15:0]            sat_count,
    output state_t                 fsm_state,
    output logic [LEVEL_W-1:0]     fifo_level
);

    logic [WORD_W-1:0]  s1_next_data;
    logic [SATN_W-1:0]  s1_next_sat;
    logic               s1_valid;
    logic [WORD_W-1:0]  s1_data;
    logic [1:0]         s1_error;
    logic [SATN_W-1:0]  s1_sat;

    logic               wr_en;
    logic               rd_en;
    logic               drop;
    logic [ENTRY_W-1:0] fifo_rd;
    logic               fifo_full;
    logic               fifo_empty;

    state_t             state;
    state_t             state_next;
    logic [LANE_W-1:0]  lane;
    logic [LANE_W-1:0]  lane_next;
    logic               load;
    logic               accept;
    logic [WORD_W-1:0]  hold_data;
    logic [1:0]         hold_error;
    logic [OUT_W-1:0]   lane_data;
    logic [16:0]        sat_sum;

    always_comb begin
        s1_next_data = '0;
        s1_next_sat  = '0;
        for (int i = 0; i < LANES; i++) begin
            round_t rr;
            rr = sat_round(bus.in_data[i*IN_W +: IN_W]);
            s1_next_data[i*OUT_W +: OUT_W] = rr.q;
            s1_next_sat = s1_next_sat + SATN_W'(rr.sat);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_error <= '0;
            s1_sat   <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            s1_data  <= s1_next_data;
            s1_error <= bus.in_error;
            s1_sat   <= s1_next_sat;
        end
    end

    // A word arriving on a full FIFO still fits when the serializer pops that cycle.
    assign wr_en = s1_valid && (!fifo_full || rd_en);
    assign drop  = s1_valid && !wr_en;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data ({s1_error, s1_data}),
        .rd_en   (rd_en),
        .rd_data (fifo_rd),
        .count   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign sat_sum = {1'b0, sat_count} + 17'(s1_sat);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_drop   <= 1'b0;
            drop_count <= '0;
            sat_count  <= '0;
        end else if (clr_stats) begin
            ovf_drop   <= 1'b0;
            drop_count <= '0;
            sat_count  <= '0;
        end else begin
            if (drop) begin
                ovf_drop <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
            if (wr_en) begin
                sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
            end
        end
    end

    assign accept = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lane       <= '0;
            hold_data  <= '0;
            hold_error <= '0;
        end else begin
            state <= state_next;
            lane  <= lane_next;
            if (load) begin
                hold_data  <= fifo_rd[WORD_W-1:0];
                hold_error <= fifo_rd[ENTRY_W-1 -: 2];
            end
        end
    end

    // Popping on the last accepted lane keeps back-to-back words bubble-free.
    always_comb begin
        state_next = state;
        lane_next  = lane;
        load       = 1'b0;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en      = 1'b1;
                    load       = 1'b1;
                    lane_next  = '0;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (accept) begin
                    if (lane == LANE_W'(LANES - 1)) begin
                        lane_next = '0;
                        if (!fifo_empty) begin
                            rd_en = 1'b1;
                            load  = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        lane_next = lane + LANE_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LANE_W'(i)) begin
                lane_data = hold_data[i*OUT_W +: OUT_W];
            end
        end
    end

    assign bus.out_valid = (state == EMIT);
    assign bus.out_data  = lane_data;
    assign bus.out_sop   = bus.out_valid && (lane == '0);
    assign bus.out_eop   = bus.out_valid && (lane == LANE_W'(LANES - 1));
    assign bus.out_error = hold_error;
    assign fsm_state     = state;

endmodule

// File: tb/tb_fir_result_serializer.sv
// Directed bench for fir_result_serializer: rounding, saturation, overflow,
// framing, error tagging, stats clear and mid-word reset.
`timescale 1ns/1ps
module tb_fir_result_serializer;
    import fir_stream_pkg::*;

    localparam int EW = ENTRY_W;

    logic               clk;
    logic               reset_n;
    logic               clr_stats;
    logic               ovf_drop;
    logic [15:0]        drop_count;
    logic [15:0]        sat_count;
    state_t             fsm_state;
    logic [LEVEL_W-1:0] fifo_level;

    fir_result_serializer_if bus();

    fir_result_serializer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .clr_stats  (clr_stats),
        .ovf_drop   (ovf_drop),
        .drop_count (drop_count),
        .sat_count  (sat_count),
        .fsm_state  (fsm_state),
        .fifo_level (fifo_level)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            mon_lane = 0;
    int            beats    = 0;
    logic [EW-1:0] mon_cur;
    logic          gap_arm  = 1'b0;
    int            gap_beats = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_lane = 0;
        end else if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_cur = exp_q[0];
                check("out_data", 64'(bus.out_data), 64'(mon_cur[mon_lane*OUT_W +: OUT_W]));
                check("out_error", 64'(bus.out_error), 64'(mon_cur[EW-1 -: 2]));
                check("out_sop", 64'(bus.out_sop), 64'(mon_lane == 0));
                check("out_eop", 64'(bus.out_eop), 64'(mon_lane == LANES - 1));
                if (bus.out_ready) begin
                    beats++;
                    if (mon_lane == LANES - 1) begin
                        mon_lane = 0;
                        void'(exp_q.pop_front());
                    end else begin
                        mon_lane++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (gap_arm) begin
            if (gap_beats > 0 && gap_beats < 4 * LANES) begin
                check("no_gap_valid", 64'(bus.out_valid), 64'd1);
            end
            if (bus.out_valid && bus.out_ready) begin
                gap_beats++;
            end
        end
    end

    // driver helpers
    function automatic logic [LANES*IN_W-1:0] pack_in(input longint v0, input longint v1,
                                                      input longint v2, input longint v3,
                                                      input longint v4);
        logic [LANES*IN_W-1:0] w;
        longint                v[LANES];
        v = '{v0, v1, v2, v3, v4};
        w = '0;
        for (int i = 0; i < LANES; i++) begin
            w[i*IN_W +: IN_W] = v[i][IN_W-1:0];
        end
        return w;
    endfunction

    function automatic logic [EW-1:0] pack_exp(input int o0, input int o1, input int o2,
                                               input int o3, input int o4, input logic [1:0] e);
        logic [EW-1:0] w;
        int            o[LANES];
        o = '{o0, o1, o2, o3, o4};
        w = '0;
        for (int i = 0; i < LANES; i++) begin
            w[i*OUT_W +: OUT_W] = o[i][OUT_W-1:0];
        end
        w[EW-1 -: 2] = e;
        return w;
    endfunction

    function automatic longint sh(input longint k);
        return k * 32768;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [LANES*IN_W-1:0] d, input logic [1:0] e);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_error = e;
        tick();
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_error = '0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && k < budget) begin
            tick();
            k++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_sop"}, 64'(bus.out_sop), 64'd0);
        check({tag, "_eop"}, 64'(bus.out_eop), 64'd0);
        check({tag, "_ovf"}, 64'(ovf_drop), 64'd0);
        check({tag, "_drops"}, 64'(drop_count), 64'd0);
        check({tag, "_sats"}, 64'(sat_count), 64'd0);
        check({tag, "_level"}, 64'(fifo_level), 64'd0);
        check({tag, "_state"}, 64'(fsm_state), 64'(IDLE));
    endtask

    initial begin
        int k;
        int b0;
        reset_n       = 1'b0;
        clr_stats     = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_error  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_data", 64'(bus.out_data), 64'd0);
        check("reset_error", 64'(bus.out_error), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // half-up rounding around +/-0.5 LSB
        bus.out_ready = 1'b1;
        exp_q.push_back(pack_exp(1, 0, 0, 0, 0, 2'b00));
        send(pack_in(16384, 0, 0, 0, 0), 2'b00);
        repeat (4) tick();
        exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 2'b00));
        send(pack_in(16383, 0, 0, 0, 0), 2'b00);
        repeat (4) tick();
        exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 2'b00));
        send(pack_in(-16384, 0, 0, 0, 0), 2'b00);
        repeat (4) tick();
        exp_q.push_back(pack_exp(-1, 0, 0, 0, 0, 2'b00));
        send(pack_in(-16385, 0, 0, 0, 0), 2'b00);
        drain(100);
        check("t1_sat_count", 64'(sat_count), 64'd0);

        // saturation on lanes 2 and 3; lane 4 is the largest unclamped value
        exp_q.push_back(pack_exp(5, -3, 32767, -32768, 32767, 2'b00));
        send(pack_in(sh(5), sh(-3), 64'sd2147483648, -64'sd2147483648, sh(32767)), 2'b00);
        drain(100);
        check("t2_sat_count", 64'(sat_count), 64'd2);

        // one word every LANES cycles streams without gaps
        gap_beats = 0;
        gap_arm   = 1'b1;
        for (int w = 0; w < 4; w++) begin
            exp_q.push_back(pack_exp(w*5+1, w*5+2, w*5+3, w*5+4, w*5+5, 2'b00));
            send(pack_in(sh(w*5+1), sh(w*5+2), sh(w*5+3), sh(w*5+4), sh(w*5+5)), 2'b00);
            repeat (4) tick();
        end
        drain(100);
        gap_arm = 1'b0;
        check("t4_beats", 64'(gap_beats), 64'd20);

        // error code travels with its word
        exp_q.push_back(pack_exp(100, 101, 102, 103, 104, 2'b10));
        send(pack_in(sh(100), sh(101), sh(102), sh(103), sh(104)), 2'b10);
        exp_q.push_back(pack_exp(-100, -101, -102, -103, -104, 2'b00));
        send(pack_in(sh(-100), sh(-101), sh(-102), sh(-103), sh(-104)), 2'b00);
        drain(100);

        // overflow: word 0 moves into the holding register, words 1..8 fill the
        // FIFO, word 9 is dropped
        bus.out_ready = 1'b0;
        for (int w = 0; w < 10; w++) begin
            if (w < 9) begin
                exp_q.push_back(pack_exp(w*8, w*8+1, w*8+2, w*8+3, w*8+4, 2'b01));
            end
            send(pack_in(sh(w*8), sh(w*8+1), sh(w*8+2), sh(w*8+3), sh(w*8+4)), 2'b01);
        end
        repeat (3) tick();
        check("t3_ovf_drop", 64'(ovf_drop), 64'd1);
        check("t3_drop_count", 64'(drop_count), 64'd1);
        check("t3_fifo_level", 64'(fifo_level), 64'(FIFO_DEPTH));
        check("t3_stalled_valid", 64'(bus.out_valid), 64'd1);
        check("t3_sat_count", 64'(sat_count), 64'd2);
        b0 = beats;
        bus.out_ready = 1'b1;
        drain(200);
        check("t3_beats", 64'(beats - b0), 64'd45);

        // clear coincident with a drop
        bus.out_ready = 1'b0;
        for (int w = 0; w < 10; w++) begin
            if (w < 9) begin
                exp_q.push_back(pack_exp(200+w*5, 201+w*5, 202+w*5, 203+w*5, 204+w*5, 2'b00));
            end
            send(pack_in(sh(200+w*5), sh(201+w*5), sh(202+w*5), sh(203+w*5), sh(204+w*5)), 2'b00);
        end
        check("t7_drop_before", 64'(drop_count), 64'd1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("t7_drop_count", 64'(drop_count), 64'd0);
        check("t7_ovf_drop", 64'(ovf_drop), 64'd0);
        check("t7_sat_count", 64'(sat_count), 64'd0);
        tick();
        check("t7_drop_count_hold", 64'(drop_count), 64'd0);
        bus.out_ready = 1'b1;
        drain(200);

        // reset after lane 2 of a word is accepted
        exp_q.push_back(pack_exp(1, 2, 3, 4, 32767, 2'b11));
        send(pack_in(sh(1), sh(2), sh(3), sh(4), 64'sd1099511627776), 2'b11);
        k = 0;
        while (mon_lane != 3 && k < 50) begin
            tick();
            k++;
        end
        check("t6_reached_lane3", 64'(mon_lane), 64'd3);
        check("t6_sat_before", 64'(sat_count), 64'd1);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check_idle_outputs("t6_reset");
        repeat (2) tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        b0 = beats;
        exp_q.push_back(pack_exp(7, 8, 9, 10, 11, 2'b00));
        send(pack_in(sh(7), sh(8), sh(9), sh(10), sh(11)), 2'b00);
        drain(100);
        check("t6_post_beats", 64'(beats - b0), 64'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
